// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch (IF)
// and data memory (DM): DM has priority, and a starvation counter forces periodic IF wins.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    input  logic [DW/8-1:0]   dm_be,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DW-1:0]     dm_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic [DW-1:0]     mem_rdata,
    output logic [1:0]        dbg_resp_own,
    output logic [3:0]        dbg_starve_cnt
);

    localparam int BW = DW / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Debug encoding: 0 = no response due, 1 = IF response due, 2 = DM response due.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } own_t;

    own_t       resp_own, resp_own_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       force_if;
    logic       if_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_own   <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            resp_own   <= resp_own_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Handshake: a requester holds *_req (and its address/data) until it sees *_gnt
    // in the same cycle; the transfer happens at that clock edge, and a read returns
    // *_rvalid with *_rdata exactly one cycle later with no backpressure.
    always_comb begin
        if_gnt         = 1'b0;
        dm_gnt         = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_be         = '0;
        resp_own_nxt   = OWN_NONE;
        starve_cnt_nxt = starve_cnt;
        force_if       = (starve_cnt == LIMIT);
        if_ok          = if_req && !if_flush;

        if (reset) begin
            if (force_if && if_ok) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (if_ok) begin
                if_gnt = 1'b1;
            end
        end

        if (if_gnt) begin
            mem_en       = 1'b1;
            mem_addr     = if_addr;
            mem_be       = {BW{1'b1}};
            resp_own_nxt = OWN_IF;
        end else if (dm_gnt) begin
            mem_en       = 1'b1;
            mem_we       = dm_we;
            mem_addr     = dm_addr;
            mem_wdata    = dm_wdata;
            mem_be       = dm_be;
            resp_own_nxt = dm_we ? OWN_NONE : OWN_DM;
        end

        // A flushed fetch that also loses to DM keeps its accumulated count.
        if (!if_req || if_gnt) begin
            starve_cnt_nxt = '0;
        end else if (if_ok && dm_gnt) begin
            starve_cnt_nxt = (starve_cnt < LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
        end else if (if_flush && !dm_gnt) begin
            starve_cnt_nxt = '0;
        end
    end

    always_comb begin
        stall_f   = reset && if_req && !if_gnt;
        stall_m   = reset && dm_req && !dm_gnt;
        if_rvalid = reset && (resp_own == OWN_IF) && !if_flush;
        dm_rvalid = reset && (resp_own == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

    assign dbg_resp_own   = resp_own;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference model (loss counter, response queue, reference memory image).
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk;
    logic          reset;
    logic          if_req, if_flush, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic [3:0]    dm_be;
    logic          stall_f, stall_m;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_be;
    logic [1:0]    dbg_resp_own;
    logic [3:0]    dbg_starve_cnt;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .dbg_resp_own(dbg_resp_own), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- memory environment ----------------
    logic [31:0] env_mem [0:127];
    logic [31:0] ref_mem [0:127];

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 0) return 32'h0050_0093;
        return {b, 8'hA5, ~b, 8'h3C};
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr[8:2]];
        else                   mem_rdata <= $urandom;
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) env_mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int          total = 0;
    int          bad   = 0;
    int          losses = 0;         // consecutive cycles a live fetch lost to DM
    int          own_q[$];           // 1 = IF, 2 = DM
    logic [31:0] exp_q[$];           // read data owed next cycle

    logic          act_if_gnt, act_dm_gnt, act_if_rvalid, act_dm_rvalid;
    logic          act_mem_we, act_stall_f;
    logic [3:0]    act_mem_be;
    logic [DW-1:0] act_if_rdata, act_dm_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0 = nobody, 1 = IF, 2 = DM
    function automatic int pick(input logic ir, input logic fl, input logic dr, input int l);
        logic ok;
        ok = ir && !fl;
        if (ok && l == LIMIT) return 1;
        if (dr)               return 2;
        if (ok)               return 1;
        return 0;
    endfunction

    // Inputs are set at a falling edge; this checks the cycle, advances the model
    // at the rising edge, and returns at the next falling edge.
    task automatic cycle();
        int          g;
        int          own;
        logic        e_ifv, e_dmv, ok;
        logic [31:0] e_ifd, e_dmd, e_addr, e_wdata;
        logic [3:0]  e_be;
        #1;
        if (!reset) begin
            own_q.delete();
            exp_q.delete();
            losses = 0;
            g = 0;
        end else begin
            g = pick(if_req, if_flush, dm_req, losses);
        end
        own     = (own_q.size() != 0) ? own_q[0] : 0;
        e_ifv   = (own == 1) && !if_flush;
        e_dmv   = (own == 2);
        e_ifd   = e_ifv ? exp_q[0] : 32'h0;
        e_dmd   = e_dmv ? exp_q[0] : 32'h0;
        e_addr  = (g == 1) ? if_addr : (g == 2) ? dm_addr : 32'h0;
        e_wdata = (g == 2) ? dm_wdata : 32'h0;
        e_be    = (g == 1) ? 4'hF : (g == 2) ? dm_be : 4'h0;

        check_eq("if_gnt",    64'(if_gnt),    64'(g == 1));
        check_eq("dm_gnt",    64'(dm_gnt),    64'(g == 2));
        check_eq("mem_en",    64'(mem_en),    64'(g != 0));
        check_eq("mem_we",    64'(mem_we),    64'((g == 2) && dm_we));
        check_eq("mem_addr",  64'(mem_addr),  64'(e_addr));
        check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        check_eq("mem_be",    64'(mem_be),    64'(e_be));
        check_eq("stall_f",   64'(stall_f),   64'(reset && if_req && g != 1));
        check_eq("stall_m",   64'(stall_m),   64'(reset && dm_req && g != 2));
        check_eq("if_rvalid", 64'(if_rvalid), 64'(e_ifv));
        check_eq("if_rdata",  64'(if_rdata),  64'(e_ifd));
        check_eq("dm_rvalid", 64'(dm_rvalid), 64'(e_dmv));
        check_eq("dm_rdata",  64'(dm_rdata),  64'(e_dmd));
        check_eq("starve_cnt",   64'(dbg_starve_cnt), 64'(losses));
        check_eq("resp_own_dbg", 64'(dbg_resp_own),   64'(own));

        act_if_gnt    = if_gnt;
        act_dm_gnt    = dm_gnt;
        act_if_rvalid = if_rvalid;
        act_dm_rvalid = dm_rvalid;
        act_if_rdata  = if_rdata;
        act_dm_rdata  = dm_rdata;
        act_mem_we    = mem_we;
        act_mem_be    = mem_be;
        act_stall_f   = stall_f;

        @(posedge clk);
        if (reset) begin
            ok = if_req && !if_flush;
            own_q.delete();
            exp_q.delete();
            if (g == 1) begin
                own_q.push_back(1);
                exp_q.push_back(ref_mem[if_addr[8:2]]);
            end else if (g == 2 && !dm_we) begin
                own_q.push_back(2);
                exp_q.push_back(ref_mem[dm_addr[8:2]]);
            end else if (g == 2) begin
                for (int b = 0; b < 4; b++)
                    if (dm_be[b]) ref_mem[dm_addr[8:2]][8*b +: 8] = dm_wdata[8*b +: 8];
            end
            if (!if_req || g == 1)            losses = 0;
            else if (ok && g == 2)            losses = (losses < LIMIT) ? losses + 1 : losses;
            else if (if_flush && g != 2)      losses = 0;
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_if(input logic req, input logic [31:0] addr, input logic flush);
        if_req   = req;
        if_addr  = addr;
        if_flush = flush;
    endtask

    task automatic drive_dm(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        dm_req   = req;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_be    = be;
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 127)) << 2;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0]  if_pat, dm_pat;
        logic [31:0] w65;
        reset = 1'b0;
        drive_if(1'b0, 32'h0, 1'b0);
        drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 128; i++) begin
            env_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        @(negedge clk);

        // reset holds everything quiet even with both requesters active
        drive_if(1'b1, 32'h0, 1'b0);
        drive_dm(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        cycle();
        check_eq("t1_rst_stall_f", 64'(act_stall_f), 64'(0));
        cycle();

        // first fetch after release
        reset = 1'b1;
        drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        check_eq("t1_if_gnt", 64'(act_if_gnt), 64'(1));
        drive_if(1'b0, 32'h0, 1'b0);
        cycle();
        check_eq("t1_if_rdata", 64'(act_if_rdata), 64'(32'h0050_0093));

        // DM wins a tie, IF follows
        drive_if(1'b1, 32'h8, 1'b0);
        drive_dm(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        cycle();
        check_eq("t2_dm_first", 64'(act_dm_gnt), 64'(1));
        check_eq("t2_stall_f",  64'(act_stall_f), 64'(1));
        drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        check_eq("t2_if_next",  64'(act_if_gnt), 64'(1));
        check_eq("t2_dm_rdata", 64'(act_dm_rdata), 64'(init_word(64)));
        drive_if(1'b0, 32'h0, 1'b0);
        cycle();
        check_eq("t2_if_rvalid", 64'(act_if_rvalid), 64'(1));

        // partial write then read-back merge
        drive_dm(1'b1, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011);
        cycle();
        check_eq("t3_mem_we", 64'(act_mem_we), 64'(1));
        check_eq("t3_mem_be", 64'(act_mem_be), 64'(4'b0011));
        drive_dm(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        cycle();
        check_eq("t3_no_wr_rvalid", 64'(act_dm_rvalid), 64'(0));
        drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        w65 = init_word(65);
        check_eq("t3_merge", 64'(act_dm_rdata), 64'({w65[31:16], 16'hBEEF}));

        // starvation limit under continuous DM pressure
        if_pat = '0;
        dm_pat = '0;
        for (int i = 0; i < 10; i++) begin
            drive_if(1'b1, 32'h10, 1'b0);
            drive_dm(1'b1, 1'b0, rnd_addr(), 32'h0, 4'h0);
            cycle();
            if_pat[i] = act_if_gnt;
            dm_pat[i] = act_dm_gnt;
        end
        check_eq("t4_if_pattern", 64'(if_pat), 64'(10'h210));
        check_eq("t4_dm_pattern", 64'(dm_pat), 64'(10'h1EF));
        drive_if(1'b0, 32'h0, 1'b0);
        drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();

        // flush kills the returning fetch and blocks a new grant
        drive_if(1'b1, 32'h20, 1'b0);
        cycle();
        check_eq("t5_if_gnt0", 64'(act_if_gnt), 64'(1));
        drive_if(1'b1, 32'h24, 1'b1);
        cycle();
        check_eq("t5_flush_gnt",    64'(act_if_gnt),    64'(0));
        check_eq("t5_flush_rvalid", 64'(act_if_rvalid), 64'(0));
        check_eq("t5_flush_rdata",  64'(act_if_rdata),  64'(0));
        drive_if(1'b1, 32'h24, 1'b0);
        cycle();
        check_eq("t5_if_gnt2", 64'(act_if_gnt), 64'(1));
        drive_if(1'b0, 32'h0, 1'b0);
        cycle();

        // reset mid-cycle drops an in-flight DM read
        drive_if(1'b1, 32'h30, 1'b0);
        drive_dm(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        cycle();
        check_eq("t6_rvalid_before", 64'(dm_rvalid), 64'(1));
        reset = 1'b0;
        drive_if(1'b0, 32'h0, 1'b0);
        drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        check_eq("t6_rvalid_in_rst", 64'(act_dm_rvalid), 64'(0));
        cycle();
        reset = 1'b1;
        cycle();
        check_eq("t6_rvalid_after", 64'(act_dm_rvalid), 64'(0));
        check_eq("t6_cnt_after",    64'(dbg_starve_cnt), 64'(0));

        // randomized traffic with held requests, flushes and occasional reset pulses
        act_if_gnt = 1'b0;
        act_dm_gnt = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!(if_req && !act_if_gnt))
                drive_if($urandom_range(0, 3) != 0, rnd_addr(), 1'b0);
            if_flush = ($urandom_range(0, 7) == 0);
            if (!(dm_req && !act_dm_gnt))
                drive_dm($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rnd_addr(),
                         $urandom, 4'($urandom_range(0, 15)));
            reset = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
